// File: rtl/pcs_tx_scheduler_if.sv
// Octet-stream frame source handshake: one octet moves on a cycle where
// valid and ready are both high; last marks the final octet, err requests TX_ER.
interface pcs_tx_scheduler_if;
    logic       valid;
    logic [7:0] data;
    logic       last;
    logic       err;
    logic       ready;

    modport master (output valid, data, last, err, input ready);
    modport slave  (input valid, data, last, err, output ready);
endinterface

// File: rtl/pcs_tx_scheduler.sv
// Round-robin frame scheduler feeding the PCS transmit path: preamble, SFD,
// payload and inter-packet gap, paced one octet per PCS advance slot.
module pcs_tx_scheduler #(
    parameter int PREAMBLE_LEN = 7,
    parameter int IPG_LEN      = 12,
    parameter int MAX_LEN      = 1518
) (
    input  logic               GTX_CLK,
    input  logic               mr_main_reset,
    input  logic               tx_adv,
    input  logic               transmitting,
    pcs_tx_scheduler_if.slave  s0,
    pcs_tx_scheduler_if.slave  s1,
    output logic [7:0]         TXD,
    output logic               TX_EN,
    output logic               TX_ER,
    output logic               grant,
    output logic               busy,
    output logic               underrun,
    output logic               jabber
);

    typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, DATA, DRAIN, IPG} state_t;

    localparam logic [3:0]  PRE_LAST  = 4'(PREAMBLE_LEN - 1);
    localparam logic [7:0]  IPG_LAST  = 8'(IPG_LEN - 1);
    localparam logic [11:0] LEN_LIMIT = 12'(MAX_LEN);

    state_t      state, state_n;
    logic [3:0]  pre_cnt, pre_cnt_n;
    logic [11:0] len_cnt, len_cnt_n;
    logic [7:0]  ipg_cnt, ipg_cnt_n;
    logic        last_grant, last_grant_n, grant_n;
    logic [7:0]  txd_n;
    logic        tx_en_n, tx_er_n, underrun_n, jabber_n;
    logic        take;
    logic        g_valid, g_last, g_err;
    logic [7:0]  g_data;

    assign g_valid  = grant ? s1.valid : s0.valid;
    assign g_data   = grant ? s1.data  : s0.data;
    assign g_last   = grant ? s1.last  : s0.last;
    assign g_err    = grant ? s1.err   : s0.err;
    assign s0.ready = take & ~grant;
    assign s1.ready = take & grant;

    always_comb begin
        state_n      = state;
        pre_cnt_n    = pre_cnt;
        len_cnt_n    = len_cnt;
        ipg_cnt_n    = ipg_cnt;
        last_grant_n = last_grant;
        grant_n      = grant;
        txd_n        = TXD;
        tx_en_n      = TX_EN;
        tx_er_n      = TX_ER;
        underrun_n   = 1'b0;
        jabber_n     = 1'b0;
        take         = 1'b0;
        case (state)
            IDLE: begin
                if (tx_adv) begin
                    txd_n   = 8'h00;
                    tx_en_n = 1'b0;
                    tx_er_n = 1'b0;
                end
                if (!transmitting && (s0.valid || s1.valid)) begin
                    grant_n      = (s0.valid && s1.valid) ? ~last_grant : s1.valid;
                    last_grant_n = grant_n;
                    pre_cnt_n    = '0;
                    len_cnt_n    = '0;
                    ipg_cnt_n    = '0;
                    state_n      = PREAMBLE;
                end
            end
            PREAMBLE: begin
                if (tx_adv) begin
                    txd_n     = 8'h55;
                    tx_en_n   = 1'b1;
                    tx_er_n   = 1'b0;
                    pre_cnt_n = pre_cnt + 4'd1;
                    if (pre_cnt == PRE_LAST) state_n = SFD;
                end
            end
            SFD: begin
                if (tx_adv) begin
                    txd_n   = 8'hD5;
                    tx_en_n = 1'b1;
                    tx_er_n = 1'b0;
                    state_n = DATA;
                end
            end
            DATA: begin
                if (tx_adv) begin
                    len_cnt_n = len_cnt + 12'd1;
                    tx_en_n   = 1'b1;
                    // The jabber slot is checked first so a valid last octet cannot slip out.
                    if (len_cnt == LEN_LIMIT) begin
                        txd_n    = 8'h00;
                        tx_er_n  = 1'b1;
                        jabber_n = 1'b1;
                        state_n  = DRAIN;
                    end else if (g_valid) begin
                        take    = 1'b1;
                        txd_n   = g_data;
                        tx_er_n = g_err;
                        if (g_last) state_n = IPG;
                    end else begin
                        txd_n      = 8'h00;
                        tx_er_n    = 1'b1;
                        underrun_n = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (tx_adv) begin
                    txd_n   = 8'h00;
                    tx_en_n = 1'b0;
                    tx_er_n = 1'b0;
                end
                take = g_valid;
                if (g_valid && g_last) state_n = IPG;
            end
            IPG: begin
                if (tx_adv) begin
                    txd_n     = 8'h00;
                    tx_en_n   = 1'b0;
                    tx_er_n   = 1'b0;
                    ipg_cnt_n = ipg_cnt + 8'd1;
                    if (ipg_cnt == IPG_LAST) state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge GTX_CLK or posedge mr_main_reset) begin
        if (mr_main_reset) begin
            state      <= IDLE;
            pre_cnt    <= '0;
            len_cnt    <= '0;
            ipg_cnt    <= '0;
            last_grant <= 1'b1;
            grant      <= 1'b0;
            busy       <= 1'b0;
            TXD        <= 8'h00;
            TX_EN      <= 1'b0;
            TX_ER      <= 1'b0;
            underrun   <= 1'b0;
            jabber     <= 1'b0;
        end else begin
            state      <= state_n;
            pre_cnt    <= pre_cnt_n;
            len_cnt    <= len_cnt_n;
            ipg_cnt    <= ipg_cnt_n;
            last_grant <= last_grant_n;
            grant      <= grant_n;
            busy       <= (state_n != IDLE);
            TXD        <= txd_n;
            TX_EN      <= tx_en_n;
            TX_ER      <= tx_er_n;
            underrun   <= underrun_n;
            jabber     <= jabber_n;
        end
    end

endmodule

// File: tb/tb_pcs_tx_scheduler.sv
// Directed bench for pcs_tx_scheduler: a vector table for one complete frame,
// then hand-written sequences for underrun, sparse pacing, jabber, reset and round-robin.
module tb_pcs_tx_scheduler;

    localparam int PRE  = 7;
    localparam int IPGL = 12;
    localparam int MAXL = 64;

    logic       GTX_CLK = 1'b0;
    logic       mr_main_reset;
    logic       tx_adv;
    logic       transmitting;
    logic [7:0] TXD;
    logic       TX_EN, TX_ER, grant, busy, underrun, jabber;

    pcs_tx_scheduler_if s0_if();
    pcs_tx_scheduler_if s1_if();

    pcs_tx_scheduler #(.PREAMBLE_LEN(PRE), .IPG_LEN(IPGL), .MAX_LEN(MAXL)) dut (
        .GTX_CLK(GTX_CLK), .mr_main_reset(mr_main_reset), .tx_adv(tx_adv),
        .transmitting(transmitting), .s0(s0_if), .s1(s1_if),
        .TXD(TXD), .TX_EN(TX_EN), .TX_ER(TX_ER), .grant(grant), .busy(busy),
        .underrun(underrun), .jabber(jabber)
    );

    always #5 GTX_CLK = ~GTX_CLK;

    typedef struct {
        logic       adv, trans, v0;
        logic [7:0] d0;
        logic       l0, rdy0;
        logic [7:0] txd;
        logic       en, er, gnt, bsy;
    } vec_t;

    vec_t       vecs[$];
    int         total = 0;
    int         bad = 0;
    logic [9:0] q0[$], q1[$];
    logic [10:0] cap[$], expq[$];
    int         grants[$], gaps[$];
    int         acc0, acc1, drop_at, cyc, zero_cnt;
    int         und_cycles, jab_cycles, en_cycles, rdy_no_adv, hold_viol;
    int         adv_period = 1;
    bit         dropped, seen_en, trans_v;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void add_vec(input logic adv, input logic trans, input logic v0,
                                    input logic [7:0] d0, input logic l0, input logic rdy0,
                                    input logic [7:0] txd, input logic en, input logic er,
                                    input logic gnt, input logic bsy);
        vec_t v;
        v.adv = adv; v.trans = trans; v.v0 = v0; v.d0 = d0; v.l0 = l0; v.rdy0 = rdy0;
        v.txd = txd; v.en = en; v.er = er; v.gnt = gnt; v.bsy = bsy;
        vecs.push_back(v);
    endfunction

    task automatic apply_stimulus(input vec_t v, input int idx);
        tx_adv = v.adv;
        transmitting = v.trans;
        s0_if.valid = v.v0; s0_if.data = v.d0; s0_if.last = v.l0; s0_if.err = 1'b0;
        s1_if.valid = 1'b0; s1_if.data = 8'h00; s1_if.last = 1'b0; s1_if.err = 1'b0;
        #1;
        check_output($sformatf("vec%0d_ready", idx), 32'({s1_if.ready, s0_if.ready}), 32'({1'b0, v.rdy0}));
        @(posedge GTX_CLK); #1;
        check_output($sformatf("vec%0d_out", idx),
                     32'({TXD, TX_EN, TX_ER, grant, busy, underrun, jabber}),
                     32'({v.txd, v.en, v.er, v.gnt, v.bsy, 2'b00}));
    endtask

    task automatic drive_sources();
        s0_if.valid = (q0.size() > 0);
        if (q0.size() > 0) {s0_if.err, s0_if.last, s0_if.data} = q0[0];
        else {s0_if.err, s0_if.last, s0_if.data} = 10'h000;
        if (drop_at >= 0 && acc0 == drop_at && !dropped && q0.size() > 0) begin
            s0_if.valid = 1'b0;
            dropped = 1'b1;
        end
        s1_if.valid = (q1.size() > 0);
        if (q1.size() > 0) {s1_if.err, s1_if.last, s1_if.data} = q1[0];
        else {s1_if.err, s1_if.last, s1_if.data} = 10'h000;
    endtask

    // One clock of the source model plus the output monitor.
    task automatic tick();
        logic       r0, r1, a, pb;
        logic [9:0] pre_out;
        tx_adv = (cyc % adv_period == 0);
        cyc++;
        transmitting = trans_v;
        drive_sources();
        #1;
        r0 = s0_if.ready; r1 = s1_if.ready; a = tx_adv; pb = busy;
        pre_out = {TXD, TX_EN, TX_ER};
        if ((r0 || r1) && !a) rdy_no_adv++;
        @(posedge GTX_CLK); #1;
        if (r0) begin q0.delete(0); acc0++; end
        if (r1) begin q1.delete(0); acc1++; end
        if (!a && {TXD, TX_EN, TX_ER} != pre_out) hold_viol++;
        if (underrun) und_cycles++;
        if (jabber) jab_cycles++;
        if (TX_EN) en_cycles++;
        if (!pb && busy) grants.push_back(int'(grant));
        if (a) begin
            if (TX_EN) begin
                cap.push_back({jabber, underrun, TX_ER, TXD});
                if (seen_en && zero_cnt > 0) gaps.push_back(zero_cnt);
                seen_en = 1'b1;
                zero_cnt = 0;
            end else if (seen_en) begin
                zero_cnt++;
            end
        end
    endtask

    task automatic clear_stats();
        cap.delete(); expq.delete(); grants.delete(); gaps.delete();
        seen_en = 1'b0; zero_cnt = 0; und_cycles = 0; jab_cycles = 0; en_cycles = 0;
        rdy_no_adv = 0; hold_viol = 0; acc0 = 0; acc1 = 0; drop_at = -1; dropped = 1'b0; cyc = 0;
    endtask

    task automatic run_frame(input string name, input int limit);
        bit seen, done;
        seen = 1'b0; done = 1'b0;
        for (int c = 0; c < limit && !done; c++) begin
            tick();
            if (busy) seen = 1'b1;
            else if (seen) done = 1'b1;
        end
        check_output({name, "_complete"}, 32'(done), 32'd1);
    endtask

    function automatic void push_exp(input logic [7:0] d, input logic er, input logic und, input logic jab);
        expq.push_back({jab, und, er, d});
    endfunction

    function automatic void push_pre();
        for (int i = 0; i < PRE; i++) push_exp(8'h55, 1'b0, 1'b0, 1'b0);
        push_exp(8'hD5, 1'b0, 1'b0, 1'b0);
    endfunction

    task automatic compare_capture(input string name);
        check_output({name, "_len"}, 32'(cap.size()), 32'(expq.size()));
        for (int i = 0; i < cap.size() && i < expq.size(); i++)
            check_output($sformatf("%s_oct%0d", name, i), 32'(cap[i]), 32'(expq[i]));
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] frame_d [4];
        frame_d[0] = 8'h11; frame_d[1] = 8'h22; frame_d[2] = 8'h33; frame_d[3] = 8'h44;

        // Single frame, tx_adv every cycle: grant, 7x55, D5, four octets, 12 IPG slots, idle.
        add_vec(1, 0, 1, 8'h11, 0, 0, 8'h00, 0, 0, 0, 1);
        for (int i = 0; i < PRE; i++) add_vec(1, 0, 1, 8'h11, 0, 0, 8'h55, 1, 0, 0, 1);
        add_vec(1, 0, 1, 8'h11, 0, 0, 8'hD5, 1, 0, 0, 1);
        for (int i = 0; i < 4; i++)
            add_vec(1, 0, 1, frame_d[i], logic'(i == 3), 1, frame_d[i], 1, 0, 0, 1);
        for (int i = 0; i < IPGL; i++)
            add_vec(1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, logic'(i != IPGL - 1));
        add_vec(1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0);

        mr_main_reset = 1'b0; tx_adv = 1'b0; transmitting = 1'b0; trans_v = 1'b0;
        s0_if.valid = 1'b0; s0_if.data = 8'h00; s0_if.last = 1'b0; s0_if.err = 1'b0;
        s1_if.valid = 1'b0; s1_if.data = 8'h00; s1_if.last = 1'b0; s1_if.err = 1'b0;
        clear_stats();
        #1 mr_main_reset = 1'b1;
        #1;
        check_output("reset_outputs", 32'({TXD, TX_EN, TX_ER, grant, busy, underrun, jabber}), 32'd0);
        @(posedge GTX_CLK); #1;
        mr_main_reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) apply_stimulus(vecs[i], i);

        // Underrun: s0 drops valid for one slot after its second octet.
        clear_stats();
        adv_period = 1;
        q0 = '{10'h001, 10'h002, 10'h003, 10'h104};
        drop_at = 2;
        run_frame("underrun", 200);
        push_pre();
        push_exp(8'h01, 0, 0, 0); push_exp(8'h02, 0, 0, 0); push_exp(8'h00, 1, 1, 0);
        push_exp(8'h03, 0, 0, 0); push_exp(8'h04, 0, 0, 0);
        compare_capture("underrun");
        check_output("underrun_pulse_cycles", 32'(und_cycles), 32'd1);
        check_output("underrun_grant_count", 32'(grants.size()), 32'd1);
        if (grants.size() > 0) check_output("underrun_grant", 32'(grants[0]), 32'd0);

        // Sparse pacing: tx_adv every second cycle, every output held two cycles.
        clear_stats();
        adv_period = 2;
        q0 = '{10'h061, 10'h062, 10'h163};
        run_frame("sparse", 300);
        push_pre();
        push_exp(8'h61, 0, 0, 0); push_exp(8'h62, 0, 0, 0); push_exp(8'h63, 0, 0, 0);
        compare_capture("sparse");
        check_output("sparse_ready_without_adv", 32'(rdy_no_adv), 32'd0);
        check_output("sparse_hold_violations", 32'(hold_viol), 32'd0);
        check_output("sparse_en_cycles", 32'(en_cycles), 32'd22);

        // Jabber: s1 streams 100 octets against MAX_LEN=64.
        clear_stats();
        adv_period = 1;
        for (int i = 1; i <= 100; i++) q1.push_back({1'b0, logic'(i == 100), 8'(i)});
        run_frame("jabber", 500);
        push_pre();
        for (int i = 1; i <= MAXL; i++) push_exp(8'(i), 0, 0, 0);
        push_exp(8'h00, 1, 0, 1);
        compare_capture("jabber");
        check_output("jabber_pulse_cycles", 32'(jab_cycles), 32'd1);
        check_output("jabber_drained", 32'(acc1), 32'd100);
        check_output("jabber_underrun_cycles", 32'(und_cycles), 32'd0);
        if (grants.size() > 0) check_output("jabber_grant", 32'(grants[0]), 32'd1);
        else check_output("jabber_grant_count", 32'(grants.size()), 32'd1);

        // Reset in the middle of the payload clears the outputs without a clock edge.
        clear_stats();
        for (int i = 0; i < 10; i++) q0.push_back({1'b0, logic'(i == 9), 8'(8'h80 + i)});
        for (int c = 0; c < 100 && acc0 < 3; c++) tick();
        check_output("rst_pre_en", 32'({TX_EN, busy}), 32'b11);
        mr_main_reset = 1'b1;
        #1;
        check_output("rst_async", 32'({TXD, TX_EN, TX_ER, grant, busy, underrun, jabber}), 32'd0);
        @(posedge GTX_CLK); #1;
        mr_main_reset = 1'b0;
        q0.delete();

        // transmitting high blocks any grant.
        clear_stats();
        for (int f = 0; f < 3; f++) begin
            q0.push_back(10'h0A0); q0.push_back(10'h1A1);
            q1.push_back(10'h0B0); q1.push_back(10'h1B1);
        end
        trans_v = 1'b1;
        for (int c = 0; c < 6; c++) tick();
        check_output("transmitting_hold", 32'(grants.size()), 32'd0);
        trans_v = 1'b0;

        // Round-robin with both sources always ready; first grant after reset is source 0.
        for (int c = 0; c < 800 && (grants.size() < 4 || gaps.size() < 3); c++) tick();
        check_output("rr_grant_count", 32'(grants.size() >= 4), 32'd1);
        for (int i = 0; i < 4 && i < grants.size(); i++)
            check_output($sformatf("rr_grant%0d", i), 32'(grants[i]), 32'(i % 2));
        check_output("rr_gap_count", 32'(gaps.size() >= 3), 32'd1);
        for (int i = 0; i < 3 && i < gaps.size(); i++)
            check_output($sformatf("rr_gap%0d", i), 32'(gaps[i]), 32'(IPGL + 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
